// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, step encodings, IR field positions.
// No logic; imported by the control unit and its decoder.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_RX_HI = 5;
    localparam int IR_RX_LO = 3;
    localparam int IR_RY_HI = 2;
    localparam int IR_RY_LO = 0;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; purely combinational, all zeros when disabled.
// Zero latency, no backpressure.
module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = 8'b0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM: steps T0..T3, decodes IR into bus selects/load enables, counts instructions.
// Outputs combinational from (step, IR, Run), effective on the same edge; no backpressure.
module unidade_controle_multiciclo
    import proc_pkg::*;
#(
    parameter int OPCODE_W  = 3,
    parameter int REG_SEL_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Run,
    input  logic [OPCODE_W+2*REG_SEL_W-1:0] IR,
    output logic                          IRin,
    output logic [2**REG_SEL_W-1:0]       Rout,
    output logic                          Gout,
    output logic                          DINout,
    output logic [2**REG_SEL_W-1:0]       Rin,
    output logic                          Ain,
    output logic                          Gin,
    output logic                          AddSub,
    output logic                          Done,
    output logic [1:0]                    Tstep,
    output logic [CNT_W-1:0]              instr_count
);

    step_t            r_step;
    step_t            w_next;
    logic [CNT_W-1:0] r_instr_count;

    logic [2:0] w_opcode;
    logic [2:0] w_rx;
    logic [2:0] w_ry;

    logic       w_irin;
    logic       w_rin_en;
    logic       w_rout_rx;
    logic       w_rout_ry;
    logic       w_gout;
    logic       w_dinout;
    logic       w_ain;
    logic       w_gin;
    logic       w_addsub;
    logic       w_done;

    logic [7:0] w_rx_oh;
    logic [7:0] w_ry_oh;

    assign w_opcode = IR[IR_OP_HI:IR_OP_LO];
    assign w_rx     = IR[IR_RX_HI:IR_RX_LO];
    assign w_ry     = IR[IR_RY_HI:IR_RY_LO];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_step <= T0;
        end else begin
            r_step <= w_next;
        end
    end

    always_comb begin
        w_next    = r_step;
        w_irin    = 1'b0;
        w_rin_en  = 1'b0;
        w_rout_rx = 1'b0;
        w_rout_ry = 1'b0;
        w_gout    = 1'b0;
        w_dinout  = 1'b0;
        w_ain     = 1'b0;
        w_gin     = 1'b0;
        w_addsub  = 1'b0;
        w_done    = 1'b0;

        case (r_step)
            T0: begin
                w_irin = Run;
                w_next = Run ? T1 : T0;
            end
            T1: begin
                case (w_opcode)
                    OP_MV: begin
                        w_rout_ry = 1'b1;
                        w_rin_en  = 1'b1;
                        w_done    = 1'b1;
                        w_next    = T0;
                    end
                    OP_MVI: begin
                        w_dinout = 1'b1;
                        w_rin_en = 1'b1;
                        w_done   = 1'b1;
                        w_next   = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout_rx = 1'b1;
                        w_ain     = 1'b1;
                        w_next    = T2;
                    end
                    default: begin
                        // Reserved opcodes retire as no-ops so software never stalls.
                        w_done = 1'b1;
                        w_next = T0;
                    end
                endcase
            end
            T2: begin
                w_rout_ry = 1'b1;
                w_gin     = 1'b1;
                w_addsub  = (w_opcode == OP_SUB);
                w_next    = T3;
            end
            T3: begin
                w_gout   = 1'b1;
                w_rin_en = 1'b1;
                w_done   = 1'b1;
                w_next   = T0;
            end
            default: begin
                w_next = T0;
            end
        endcase

        // T2/T3 are only reachable through an ALU opcode; guard against IR changing mid-instruction.
        if ((r_step == T2 || r_step == T3) && !is_alu_op(w_opcode)) begin
            w_rout_ry = 1'b0;
            w_gin     = 1'b0;
            w_addsub  = 1'b0;
            w_gout    = 1'b0;
            w_rin_en  = 1'b0;
            w_done    = 1'b1;
            w_next    = T0;
        end
    end

    dec3to8 u_dec_rx (
        .i_en     (w_rin_en | w_rout_rx),
        .i_sel    (w_rx),
        .o_onehot (w_rx_oh)
    );

    dec3to8 u_dec_ry (
        .i_en     (w_rout_ry),
        .i_sel    (w_ry),
        .o_onehot (w_ry_oh)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_instr_count <= '0;
        end else if (w_done) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign IRin        = w_irin;
    assign Rin         = w_rin_en ? w_rx_oh : 8'b0;
    assign Rout        = (w_rout_rx ? w_rx_oh : 8'b0) | w_ry_oh;
    assign Gout        = w_gout;
    assign DINout      = w_dinout;
    assign Ain         = w_ain;
    assign Gin         = w_gin;
    assign AddSub      = w_addsub;
    assign Done        = w_done;
    assign Tstep       = r_step;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit; a second instance with a 3-bit counter covers wrap.
module tb_unidade_controle_multiciclo;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [8:0]  IR;

    logic        IRin, Gout, DINout, Ain, Gin, AddSub, Done;
    logic [7:0]  Rout, Rin;
    logic [1:0]  Tstep;
    logic [15:0] instr_count;

    logic        n_IRin, n_Gout, n_DINout, n_Ain, n_Gin, n_AddSub, n_Done;
    logic [7:0]  n_Rout, n_Rin;
    logic [1:0]  n_Tstep;
    logic [2:0]  n_instr_count;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    always #5 Clock = ~Clock;

    unidade_controle_multiciclo u_dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR),
        .IRin(IRin), .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .Tstep(Tstep),
        .instr_count(instr_count)
    );

    unidade_controle_multiciclo #(.CNT_W(3)) u_dut_narrow (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR),
        .IRin(n_IRin), .Rout(n_Rout), .Gout(n_Gout), .DINout(n_DINout), .Rin(n_Rin),
        .Ain(n_Ain), .Gin(n_Gin), .AddSub(n_AddSub), .Done(n_Done), .Tstep(n_Tstep),
        .instr_count(n_instr_count)
    );

    logic [22:0] w_ctl;
    assign w_ctl = {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};

    always @(negedge Clock) begin
        if (!Reset) begin
            assert ($countones({Rout, Gout, DINout}) <= 1)
                else $error("bus has multiple drivers: Rout=%b Gout=%b DINout=%b", Rout, Gout, DINout);
        end
    end

    function automatic logic [22:0] ctl(input logic irin, input logic [7:0] rout,
                                        input logic gout, input logic din,
                                        input logic [7:0] rin, input logic ain,
                                        input logic gin, input logic addsub,
                                        input logic done);
        return {irin, rout, gout, din, rin, ain, gin, addsub, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic now(input string tag, input logic [1:0] t, input logic [22:0] c);
        #1;
        chk({tag, "_T"}, 32'(Tstep), 32'(t));
        chk({tag, "_ctl"}, 32'(w_ctl), 32'(c));
        chk({tag, "_bus"}, 32'($onehot0({Rout, Gout, DINout})), 32'd1);
    endtask

    task automatic step(input string tag, input logic [1:0] t, input logic [22:0] c);
        @(negedge Clock);
        now(tag, t, c);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt"}, 32'(instr_count), 32'(exp_cnt % 65536));
        chk({tag, "_cnt3"}, 32'(n_instr_count), 32'(exp_cnt % 8));
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b1;
        IR    = 9'b0;
        #2;
        chk("rst_T", 32'(Tstep), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        chk("rst_ctl", 32'(w_ctl), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        Run = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step("idle", 2'd0, '0);
        chk_cnt("idle");

        // mvi R1,#5
        IR = 9'b001_001_000; Run = 1'b1;
        now("mvi_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("mvi_t1", 2'd1, ctl(0, 0, 0, 1, 8'h02, 0, 0, 0, 1));
        Run = 1'b0;
        step("mvi_end", 2'd0, '0);
        exp_cnt = 1;
        chk_cnt("mvi");

        // add R0,R1 then sub R0,R1 back to back
        IR = 9'b010_000_001; Run = 1'b1;
        now("add_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("add_t1", 2'd1, ctl(0, 8'h01, 0, 0, 0, 1, 0, 0, 0));
        step("add_t2", 2'd2, ctl(0, 8'h02, 0, 0, 0, 0, 1, 0, 0));
        step("add_t3", 2'd3, ctl(0, 0, 1, 0, 8'h01, 0, 0, 0, 1));
        @(negedge Clock);
        IR = 9'b011_000_001;
        now("sub_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("sub_t1", 2'd1, ctl(0, 8'h01, 0, 0, 0, 1, 0, 0, 0));
        step("sub_t2", 2'd2, ctl(0, 8'h02, 0, 0, 0, 0, 1, 1, 0));
        step("sub_t3", 2'd3, ctl(0, 0, 1, 0, 8'h01, 0, 0, 0, 1));
        exp_cnt = 3;

        // mv R0,R1
        @(negedge Clock);
        chk_cnt("addsub");
        IR = 9'b000_000_001;
        now("mv_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("mv_t1", 2'd1, ctl(0, 8'h02, 0, 0, 8'h01, 0, 0, 0, 1));

        // mv R3,R3
        @(negedge Clock);
        IR = 9'b000_011_011;
        now("mv33_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("mv33_t1", 2'd1, ctl(0, 8'h08, 0, 0, 8'h08, 0, 0, 0, 1));

        // add R2,R2
        @(negedge Clock);
        IR = 9'b010_010_010;
        exp_cnt = 5;
        now("add22_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_cnt("mv");
        step("add22_t1", 2'd1, ctl(0, 8'h04, 0, 0, 0, 1, 0, 0, 0));
        step("add22_t2", 2'd2, ctl(0, 8'h04, 0, 0, 0, 0, 1, 0, 0));
        step("add22_t3", 2'd3, ctl(0, 0, 1, 0, 8'h04, 0, 0, 0, 1));

        // reserved 111, then reserved 100 pushes the narrow counter through its wrap
        @(negedge Clock);
        IR = 9'b111_101_110;
        now("rsv7_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rsv7_t1", 2'd1, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge Clock);
        exp_cnt = 7;
        chk_cnt("rsv7");
        IR = 9'b100_001_010;
        step("rsv4_t1", 2'd1, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge Clock);
        exp_cnt = 8;
        chk_cnt("wrap");
        IR = 9'b001_111_000;
        step("mvi7_t1", 2'd1, ctl(0, 0, 0, 1, 8'h80, 0, 0, 0, 1));
        @(negedge Clock);
        exp_cnt = 9;
        chk_cnt("postwrap");

        // async reset in T2 of an add
        IR = 9'b010_000_001;
        step("abort_t1", 2'd1, ctl(0, 8'h01, 0, 0, 0, 1, 0, 0, 0));
        Run = 1'b0;
        step("abort_t2", 2'd2, ctl(0, 8'h02, 0, 0, 0, 0, 1, 0, 0));
        Reset = 1'b1;
        exp_cnt = 0;
        now("abort_rst", 2'd0, '0);
        chk_cnt("abort_rst");
        step("abort_hold", 2'd0, '0);
        chk_cnt("abort_hold");
        Reset = 1'b0;
        step("abort_idle", 2'd0, '0);
        chk_cnt("abort_idle");

        // one more mvi after the abort
        IR = 9'b001_010_000; Run = 1'b1;
        now("mvi2_t0", 2'd0, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("mvi2_t1", 2'd1, ctl(0, 0, 0, 1, 8'h04, 0, 0, 0, 1));
        Run = 1'b0;
        step("mvi2_end", 2'd0, '0);
        exp_cnt = 1;
        chk_cnt("mvi2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Control FSM that sequences the multicycle processor datapath: eight registers R0..R7, A, G, IR, adder/subtractor and a shared 16-bit BusWires.
- Steps through T0..T3 per instruction, decodes the IR fields and drives every bus-source select and register load enable.
- Raises Done on the final step of each instruction and counts completed instructions for board debug.
- Sits inside processador_multiciclo, between the Run switch/IR register and the datapath muxes.

Parameters:
- OPCODE_W, 3, opcode field width (IR[8:6]).
- REG_SEL_W, 3, register field width; number of registers = 2**REG_SEL_W = 8.
- CNT_W, 16, width of the completed-instruction counter.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  start request; sampled only in step T0.
- IR  input  9  instruction register contents: [8:6] opcode, [5:3] Rx, [2:0] Ry.
- IRin  output  1  load enable for the IR (captures DIN).
- Rout  output  8  one-hot bus source select for R0..R7.
- Gout  output  1  G drives the bus.
- DINout  output  1  DIN drives the bus.
- Rin  output  8  one-hot load enable for R0..R7.
- Ain  output  1  load enable for A.
- Gin  output  1  load enable for G.
- AddSub  output  1  0 = add, 1 = subtract.
- Done  output  1  instruction completes this cycle.
- Tstep  output  2  current step, for LED debug.
- instr_count  output  CNT_W  number of completed instructions.

Behaviour:
- Step register Tstep: T0=0, T1=1, T2=2, T3=3.
- Reset (async): Tstep=T0 and instr_count=0 immediately. All control outputs then evaluate to 0 while Run is low.
- Reset mid-instruction: the FSM aborts to T0. No Rin, Ain or Gin is asserted on the following edge.
- Control outputs are combinational from (Tstep, IR, Run). There are no registered control outputs, so latency from a step to its effect is the same edge.
- T0: IRin = Run. Next state is T1 if Run=1, else T0. Run is ignored in T1..T3.
- Opcode 000, mv Rx,Ry:
  - T1: Rout[Ry]=1, Rin[Rx]=1, Done=1; next T0.
- Opcode 001, mvi Rx,#D:
  - T1: DINout=1, Rin[Rx]=1, Done=1; next T0.
- Opcode 010, add Rx,Ry:
  - T1: Rout[Rx]=1, Ain=1; next T2.
  - T2: Rout[Ry]=1, Gin=1, AddSub=0; next T3.
  - T3: Gout=1, Rin[Rx]=1, Done=1; next T0.
- Opcode 011, sub: identical to add except AddSub=1 in T2. AddSub is 0 in every other step.
- Opcodes 100..111 are reserved: T1 asserts Done only, with no bus driver and no load; next T0.
- Rx=Ry is legal: mv R3,R3 is a no-op write; add R2,R2 doubles R2.
- Bus invariant: in every cycle at most one of {Rout[7:0], Gout, DINout} is high. Multiple drivers are a design error; verification checks this with an assertion every cycle.
- Rin and Rout are always one-hot or zero.
- Done is high for exactly one cycle per instruction, and next state is always T0 after Done.
- A back-to-back instruction needs Run high in T0. Minimum cycles per instruction: 2 for mv/mvi/reserved, 4 for add/sub.
- instr_count increments on each rising edge where Done=1. It wraps from 2**CNT_W-1 to 0 with no saturation or flag.
- IR must be stable in T1..T3. The controller never asserts IRin outside T0.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011;
  - step encodings T0..T3;
  - IR field bit positions.
- Reuse one sub-module, dec3to8, a 3-to-8 one-hot decoder with enable. It is instantiated twice, for the Rx and Ry fields, and feeds Rin and Rout.

Test Plan:
- Reset check: Reset=1 with Run=1 -> Tstep=0, instr_count=0, and all control outputs 0 except IRin=1. Release Reset with Run=0 -> FSM stays in T0 for 5 cycles.
- mvi R1,#5: IR=9'b001_001_000, Run=1 -> edge 1: T1 with DINout=1, Rin=8'b0000_0010, Done=1. Edge 2: T0 and instr_count=1.
- mv R0,R1: IR=9'b000_000_001 -> T1 has Rout=8'b0000_0010, Rin=8'b0000_0001, Done=1. Bus one-hot assertion holds throughout.
- add R0,R1 then sub R0,R1: T1 Rout[0]=1, Ain=1; T2 Rout[1]=1, Gin=1, AddSub=0 (1 for sub); T3 Gout=1, Rin[0]=1, Done=1. 8 cycles total, instr_count=2.
- Reset asserted asynchronously in T2 of an add -> Tstep=0 before the next edge. No Rin pulse ever appears. instr_count does not increment.
- Reserved opcode 111 -> Done in T1 with Rin=0, Rout=0, Ain=Gin=0. Separately, force instr_count to 16'hFFFF and run one mvi -> instr_count=0.
